// File: rtl/icb_pkg.sv
// rtl/icb_pkg.sv - shared state encoding and bus geometry for the ICB DMA master
`ifndef ICB_WIDTH
`define ICB_WIDTH 32
`endif

package icb_pkg;

   localparam int ICB_W = `ICB_WIDTH;
   localparam int BPW   = ICB_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_CMD = 3'd1,
      ST_RD_RSP = 3'd2,
      ST_WR_CMD = 3'd3,
      ST_WR_RSP = 3'd4,
      ST_FIN    = 3'd5
   } dma_state_e;

   // Word-stride increment; wraps silently at the top of the address space.
   function automatic logic [ICB_W-1:0] next_word_addr(input logic [ICB_W-1:0] addr);
      return addr + ICB_W'(BPW);
   endfunction

endpackage

// File: rtl/icb_dma_master.sv
// rtl/icb_dma_master.sv - single-outstanding ICB memory-to-memory copy engine
module icb_dma_master
   import icb_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [ICB_W-1:0] src_addr_i,
   input  logic [ICB_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             icb_cmd_valid_o,
   input  logic             icb_cmd_ready_i,
   output logic [ICB_W-1:0] icb_cmd_addr_o,
   output logic             icb_cmd_read_o,
   output logic [ICB_W-1:0] icb_cmd_wdata_o,
   output logic [BPW-1:0]   icb_cmd_wmask_o,
   input  logic             icb_rsp_valid_i,
   output logic             icb_rsp_ready_o,
   input  logic [ICB_W-1:0] icb_rsp_rdata_i,
   input  logic             icb_rsp_err_i
);

   dma_state_e       state_q, state_d;
   logic [ICB_W-1:0] cur_src_q;
   logic [ICB_W-1:0] cur_dst_q;
   logic [ICB_W-1:0] data_q;
   logic [LEN_W-1:0] remaining_q;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command fields come straight from registers, so they hold while the responder stalls.
   always_comb begin
      state_d         = state_q;
      busy_o          = (state_q != ST_IDLE);
      done_o          = 1'b0;
      icb_cmd_valid_o = 1'b0;
      icb_cmd_read_o  = 1'b0;
      icb_cmd_addr_o  = '0;
      icb_cmd_wdata_o = '0;
      icb_cmd_wmask_o = '0;
      icb_rsp_ready_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = (len_i == '0) ? ST_FIN : ST_RD_CMD;
            end
         end
         ST_RD_CMD: begin
            icb_cmd_valid_o = 1'b1;
            icb_cmd_read_o  = 1'b1;
            icb_cmd_addr_o  = cur_src_q;
            if (icb_cmd_ready_i) begin
               state_d = ST_RD_RSP;
            end
         end
         ST_RD_RSP: begin
            icb_rsp_ready_o = 1'b1;
            if (icb_rsp_valid_i) begin
               state_d = icb_rsp_err_i ? ST_FIN : ST_WR_CMD;
            end
         end
         ST_WR_CMD: begin
            icb_cmd_valid_o = 1'b1;
            icb_cmd_addr_o  = cur_dst_q;
            icb_cmd_wdata_o = data_q;
            icb_cmd_wmask_o = '1;
            if (icb_cmd_ready_i) begin
               state_d = ST_WR_RSP;
            end
         end
         ST_WR_RSP: begin
            icb_rsp_ready_o = 1'b1;
            if (icb_rsp_valid_i) begin
               if (icb_rsp_err_i || (remaining_q == LEN_W'(1))) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_RD_CMD;
               end
            end
         end
         ST_FIN: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_src_q   <= '0;
         cur_dst_q   <= '0;
         data_q      <= '0;
         remaining_q <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  cur_src_q   <= src_addr_i;
                  cur_dst_q   <= dst_addr_i;
                  remaining_q <= len_i;
                  err_q       <= 1'b0;
               end
            end
            ST_RD_RSP: begin
               if (icb_rsp_valid_i) begin
                  if (icb_rsp_err_i) begin
                     err_q <= 1'b1;
                  end else begin
                     data_q <= icb_rsp_rdata_i;
                  end
               end
            end
            ST_WR_RSP: begin
               if (icb_rsp_valid_i) begin
                  if (icb_rsp_err_i) begin
                     err_q <= 1'b1;
                  end else begin
                     remaining_q <= remaining_q - LEN_W'(1);
                     cur_src_q   <= next_word_addr(cur_src_q);
                     cur_dst_q   <= next_word_addr(cur_dst_q);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_icb_dma_master.sv
// tb/tb_icb_dma_master.sv - randomized scoreboard bench for icb_dma_master
module tb_icb_dma_master;
   import icb_pkg::*;

   localparam int LEN_W = 16;

   typedef struct packed {
      logic             rd;
      logic [ICB_W-1:0] addr;
      logic [ICB_W-1:0] wdata;
      logic [BPW-1:0]   wmask;
   } cmd_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic [ICB_W-1:0] src_addr_i = '0;
   logic [ICB_W-1:0] dst_addr_i = '0;
   logic [LEN_W-1:0] len_i = '0;
   logic             busy_o, done_o, err_o;
   logic             icb_cmd_valid_o;
   logic             icb_cmd_ready_i = 1'b0;
   logic [ICB_W-1:0] icb_cmd_addr_o;
   logic             icb_cmd_read_o;
   logic [ICB_W-1:0] icb_cmd_wdata_o;
   logic [BPW-1:0]   icb_cmd_wmask_o;
   logic             icb_rsp_valid_i = 1'b0;
   logic             icb_rsp_ready_o;
   logic [ICB_W-1:0] icb_rsp_rdata_i = '0;
   logic             icb_rsp_err_i = 1'b0;

   icb_dma_master #(.LEN_W(LEN_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .src_addr_i      (src_addr_i),
      .dst_addr_i      (dst_addr_i),
      .len_i           (len_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .icb_cmd_valid_o (icb_cmd_valid_o),
      .icb_cmd_ready_i (icb_cmd_ready_i),
      .icb_cmd_addr_o  (icb_cmd_addr_o),
      .icb_cmd_read_o  (icb_cmd_read_o),
      .icb_cmd_wdata_o (icb_cmd_wdata_o),
      .icb_cmd_wmask_o (icb_cmd_wmask_o),
      .icb_rsp_valid_i (icb_rsp_valid_i),
      .icb_rsp_ready_o (icb_rsp_ready_o),
      .icb_rsp_rdata_i (icb_rsp_rdata_i),
      .icb_rsp_err_i   (icb_rsp_err_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   cmd_t             obs_q[$];
   logic [ICB_W-1:0] mem [logic [ICB_W-1:0]];
   bit               rand_mode = 1'b0;
   int               err_idx = -1;
   int               rd_count = 0;
   int               wr_stall = 0;
   int               stall_seen = 0;
   bit               rsp_pend = 1'b0;
   bit               rsp_clr = 1'b0;
   bit               prev_stall = 1'b0;
   cmd_t             prev_cmd;
   cmd_t             cur_cmd;
   logic [ICB_W-1:0] nxt_rdata = '0;
   logic             nxt_err = 1'b0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [ICB_W-1:0] mem_rd(input logic [ICB_W-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   // Responder: drives at the falling edge, observes handshakes 1ns later.
   initial begin
      forever begin
         @(negedge clk);
         if (rsp_clr) begin
            icb_rsp_valid_i = 1'b0;
            icb_rsp_rdata_i = '0;
            icb_rsp_err_i   = 1'b0;
            rsp_clr         = 1'b0;
         end
         if (wr_stall > 0 && icb_cmd_valid_o && !icb_cmd_read_o) begin
            icb_cmd_ready_i = 1'b0;
            wr_stall--;
            stall_seen++;
         end else begin
            icb_cmd_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (rsp_pend && !icb_rsp_valid_i && (!rand_mode || $urandom_range(0, 2) != 0)) begin
            icb_rsp_valid_i = 1'b1;
            icb_rsp_rdata_i = nxt_rdata;
            icb_rsp_err_i   = nxt_err;
         end
         #1;
         if (rst) begin
            rsp_pend        = 1'b0;
            rsp_clr         = 1'b0;
            prev_stall      = 1'b0;
            icb_rsp_valid_i = 1'b0;
            icb_rsp_rdata_i = '0;
            icb_rsp_err_i   = 1'b0;
         end else begin
            cur_cmd = '{rd: icb_cmd_read_o, addr: icb_cmd_addr_o,
                        wdata: icb_cmd_wdata_o, wmask: icb_cmd_wmask_o};
            if (prev_stall) begin
               check("cmd_hold_valid", icb_cmd_valid_o, 1'b1);
               check("cmd_hold_fields", cur_cmd, prev_cmd);
            end
            if (icb_cmd_valid_o && icb_cmd_ready_i) begin
               check("one_outstanding", rsp_pend, 1'b0);
               obs_q.push_back(cur_cmd);
               rsp_pend = 1'b1;
               if (cur_cmd.rd) begin
                  nxt_rdata = mem_rd(cur_cmd.addr);
                  nxt_err   = (rd_count == err_idx);
                  rd_count++;
               end else begin
                  mem[cur_cmd.addr] = cur_cmd.wdata;
                  nxt_rdata = '0;
                  nxt_err   = 1'b0;
               end
            end
            if (icb_rsp_valid_i && icb_rsp_ready_o) begin
               rsp_pend = 1'b0;
               rsp_clr  = 1'b1;
            end
            prev_stall = icb_cmd_valid_o && !icb_cmd_ready_i;
            prev_cmd   = cur_cmd;
         end
      end
   end

   task automatic run_xfer(input logic [ICB_W-1:0] src, input logic [ICB_W-1:0] dst,
                           input int len, input int eidx, input int pulse_at, input bit timed);
      cmd_t             exp_q[$];
      logic [ICB_W-1:0] a;
      bit               exp_err;
      int               exp_cycles;
      int               cyc;
      exp_q = {};
      for (int i = 0; i < len; i++) begin
         a = src + ICB_W'(BPW * i);
         exp_q.push_back('{rd: 1'b1, addr: a, wdata: '0, wmask: '0});
         if (i == eidx) break;
         exp_q.push_back('{rd: 1'b0, addr: dst + ICB_W'(BPW * i), wdata: mem_rd(a), wmask: '1});
      end
      exp_err    = (eidx >= 0) && (eidx < len);
      exp_cycles = (len == 0) ? 1 : (exp_err ? 4 * eidx + 3 : 4 * len + 1);
      obs_q.delete();
      rd_count = 0;
      err_idx  = eidx;
      start_i    = 1'b1;
      src_addr_i = src;
      dst_addr_i = dst;
      len_i      = LEN_W'(len);
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1;
      check("err_cleared_on_start", err_o, 1'b0);
      while (!done_o && cyc < 2000) begin
         check("busy_during_xfer", busy_o, 1'b1);
         if (cyc == pulse_at) begin
            start_i    = 1'b1;
            src_addr_i = 32'h0000_4000;
            dst_addr_i = 32'h0000_5000;
            len_i      = LEN_W'(5);
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start_i = 1'b0;
      check("done_seen", done_o, 1'b1);
      check("busy_at_done", busy_o, 1'b1);
      if (timed) check("done_latency", cyc, exp_cycles);
      @(negedge clk);
      check("done_single_pulse", done_o, 1'b0);
      check("busy_after_done", busy_o, 1'b0);
      check("err_result", err_o, exp_err);
      check("cmd_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs_q.size()) check($sformatf("cmd_%0d", i), obs_q[i], exp_q[i]);
      end
      repeat (2) @(negedge clk);
      check("err_sticky", err_o, exp_err);
      check("idle_no_cmd", icb_cmd_valid_o, 1'b0);
      check("idle_no_rsp_ready", icb_rsp_ready_o, 1'b0);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_cmd_valid", icb_cmd_valid_o, 1'b0);
      check("rst_rsp_ready", icb_rsp_ready_o, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      run_xfer(32'h0000_0100, 32'h0000_0200, 3, -1, 0, 1'b1);
      run_xfer(32'h0000_0100, 32'h0000_0200, 0, -1, 0, 1'b1);

      wr_stall = 5;
      stall_seen = 0;
      run_xfer(32'h0000_0400, 32'h0000_0480, 3, -1, 0, 1'b0);
      check("stall_cycles", stall_seen, 5);

      run_xfer(32'h0000_0700, 32'h0000_0780, 4, 1, 0, 1'b1);
      run_xfer(32'hFFFF_FFFC, 32'h0000_0300, 2, -1, 3, 1'b1);

      obs_q.delete();
      err_idx = -1;
      start_i = 1'b1; src_addr_i = 32'h0000_0500; dst_addr_i = 32'h0000_0600; len_i = LEN_W'(3);
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
      while (!(icb_cmd_valid_o && !icb_cmd_read_o) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_wr_cmd", icb_cmd_valid_o && !icb_cmd_read_o, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_cmd_valid", icb_cmd_valid_o, 1'b0);
      check("abort_busy", busy_o, 1'b0);
      check("abort_rsp_ready", icb_rsp_ready_o, 1'b0);
      check("abort_err", err_o, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("abort_no_done", done_o, 1'b0);
         @(negedge clk);
      end
      run_xfer(32'h0000_0500, 32'h0000_0600, 2, -1, 0, 1'b1);

      rand_mode = 1'b1;
      for (int t = 0; t < 24; t++) begin
         int len, eidx;
         len  = $urandom_range(0, 6);
         eidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         run_xfer(32'h0000_1000 + ICB_W'(4 * $urandom_range(0, 255)),
                  32'h0000_8000 + ICB_W'(4 * $urandom_range(0, 255)),
                  len, eidx, $urandom_range(2, 6), 1'b0);
      end
      rand_mode = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
